// File: rtl/ether_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ether_pkg: shared types, constants and CRC step for RMII framing |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ether_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        DATA     = 3'd3,
        FCS      = 3'd4,
        IFG      = 3'd5
    } tx_state_t;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;
    localparam int          PREAMBLE_LEN   = 31;
    localparam int          FCS_DIBITS     = 16;
    localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;

    // Reflected CRC-32 advanced by one dibit, din[0] is the earlier bit.
    function automatic logic [31:0] crc32_dibit_next(input logic [31:0] crc_in,
                                                     input logic [1:0]  din);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 2; i++) begin
            c = (c[0] ^ din[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_dibit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc32_dibit: running Ethernet CRC-32 over a 2-bit/clk stream     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module crc32_dibit
    import ether_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  din,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Clear wins over enable so a new frame never inherits stale state.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc32_dibit_next(crc_q, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/ether_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ether_tx: RMII transmit framer (preamble/SFD, payload, FCS, IFG) |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ether_tx
    import ether_pkg::*;
#(
    parameter bit APPEND_FCS = 1'b1,
    parameter int IFG_DIBITS = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiir,
    output logic       txen,
    output logic [1:0] txd,
    output logic       busy,
    output logic       runt
);

    localparam int CNT_W = ($clog2(IFG_DIBITS + 1) > 5) ? $clog2(IFG_DIBITS + 1) : 5;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_DIBITS - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_DIBITS - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      fcs_sr_q, fcs_sr_d;
    logic             txen_q, txen_d;
    logic [1:0]       txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             runt_q, runt_d;

    logic             w_crc_clr;
    logic             w_crc_en;
    logic [31:0]      w_crc;
    logic [31:0]      w_fcs;

    crc32_dibit u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_crc_clr),
        .en    (w_crc_en),
        .din   (axiid),
        .crc   (w_crc)
    );

    assign w_fcs = ~w_crc;
    assign axiir = (state_q == SFD) || (state_q == DATA);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fcs_sr_d  = fcs_sr_q;
        txen_d    = txen_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        runt_d    = 1'b0;
        w_crc_clr = 1'b0;
        w_crc_en  = 1'b0;

        case (state_q)
            IDLE: begin
                txen_d = 1'b0;
                txd_d  = 2'b00;
                busy_d = 1'b0;
                // The start request is only a trigger; the dibit is consumed in SFD.
                if (axiiv) begin
                    state_d   = PREAMBLE;
                    cnt_d     = CNT_W'(1);
                    txen_d    = 1'b1;
                    txd_d     = PREAMBLE_DIBIT;
                    busy_d    = 1'b1;
                    w_crc_clr = 1'b1;
                end
            end

            PREAMBLE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                    cnt_d   = '0;
                    txd_d   = SFD_DIBIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    txd_d = PREAMBLE_DIBIT;
                end
            end

            SFD, DATA: begin
                cnt_d = '0;
                if (axiiv) begin
                    state_d  = DATA;
                    txd_d    = axiid;
                    w_crc_en = 1'b1;
                end else begin
                    runt_d = (state_q == SFD);
                    if (APPEND_FCS) begin
                        // crc already covers every consumed dibit, so the FCS is final here.
                        state_d  = FCS;
                        txd_d    = w_fcs[1:0];
                        fcs_sr_d = {2'b00, w_fcs[31:2]};
                    end else begin
                        state_d = IFG;
                        txen_d  = 1'b0;
                        txd_d   = 2'b00;
                    end
                end
            end

            FCS: begin
                if (cnt_q == FCS_LAST) begin
                    state_d = IFG;
                    cnt_d   = '0;
                    txen_d  = 1'b0;
                    txd_d   = 2'b00;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    txd_d    = fcs_sr_q[1:0];
                    fcs_sr_d = {2'b00, fcs_sr_q[31:2]};
                end
            end

            IFG: begin
                txen_d = 1'b0;
                txd_d  = 2'b00;
                if (cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                txen_d  = 1'b0;
                txd_d   = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fcs_sr_q <= '0;
            txen_q   <= 1'b0;
            txd_q    <= 2'b00;
            busy_q   <= 1'b0;
            runt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fcs_sr_q <= fcs_sr_d;
            txen_q   <= txen_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            runt_q   <= runt_d;
        end
    end

    assign txen = txen_q;
    assign txd  = txd_q;
    assign busy = busy_q;
    assign runt = runt_q;

endmodule
`default_nettype wire

// File: tb/tb_ether_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ether_tx: directed self-checking bench for the RMII framer    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ether_tx;

    logic       clk;
    logic       rst_n;
    logic       axiiv;
    logic [1:0] axiid;
    logic       sel;

    logic       axiiv_a, axiir_a, txen_a, busy_a, runt_a;
    logic       axiiv_b, axiir_b, txen_b, busy_b, runt_b;
    logic [1:0] txd_a, txd_b;
    logic       w_axiir, w_txen, w_busy, w_runt;
    logic [1:0] w_txd;

    int         n_cmp;
    int         n_err;
    int         runts;
    int         pre;
    int         gap_axiir;
    logic [1:0] pay[$];
    logic [1:0] cap[$];

    // DUT a appends the FCS, DUT b does not; sel routes the stream to one of them.
    assign axiiv_a = axiiv & ~sel;
    assign axiiv_b = axiiv & sel;
    assign w_axiir = sel ? axiir_b : axiir_a;
    assign w_txen  = sel ? txen_b  : txen_a;
    assign w_txd   = sel ? txd_b   : txd_a;
    assign w_busy  = sel ? busy_b  : busy_a;
    assign w_runt  = sel ? runt_b  : runt_a;

    ether_tx #(.APPEND_FCS(1'b1), .IFG_DIBITS(48)) dut (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv_a), .axiid(axiid), .axiir(axiir_a),
        .txen(txen_a), .txd(txd_a), .busy(busy_a), .runt(runt_a)
    );

    ether_tx #(.APPEND_FCS(1'b0), .IFG_DIBITS(48)) dut_nf (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv_b), .axiid(axiid), .axiir(axiir_b),
        .txen(txen_b), .txd(txd_b), .busy(busy_b), .runt(runt_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic load_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) pay.push_back(b[2*k +: 2]);
    endtask

    function automatic logic [1:0] capd(input int i);
        if (i < cap.size()) return cap[i];
        return 2'bxx;
    endfunction

    // Bit-serial software CRC-32 (reflected) over q[from .. from+n-1], each dibit bit0 first.
    function automatic logic [31:0] crc_run(input logic [1:0] q[$], input int from, input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int k = from; k < from + n; k++) begin
            for (int b = 0; b < 2; b++) begin
                fb = c[0] ^ q[k][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    // Drives one frame of ndib payload dibits and records txd while txen is high.
    // Returns on the first txen=0 sample after the frame (first IFG cycle).
    task automatic send(input bit use_nf, input int ndib, input bit hold, input int abort_at);
        int idx;
        bit started;
        bit done;
        sel = use_nf;
        cap.delete();
        runts = 0; pre = 0; idx = 0; started = 0; done = 0;
        axiiv = 1'b1;
        axiid = (ndib > 0) ? pay[0] : 2'b00;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(negedge clk);
            if (w_runt) runts++;
            if (w_txen) begin
                started = 1;
                cap.push_back(w_txd);
                if (cap.size() == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    n_cmp++;
                    if (w_txen !== 1'b0 || w_axiir !== 1'b0) begin
                        n_err++;
                        $display("FAIL abort_async: txen=%b axiir=%b, want 0 0", w_txen, w_axiir);
                    end
                    done = 1;
                end
            end else if (started) begin
                done = 1;
                if (w_axiir) gap_axiir++;
            end else begin
                pre++;
                if (w_axiir) gap_axiir++;
            end
            if (!done) begin
                if (w_axiir) begin
                    if (idx < ndib) begin
                        axiiv = 1'b1; axiid = pay[idx]; idx++;
                    end else begin
                        axiiv = 1'b0; axiid = 2'b00;
                    end
                end else if (idx >= ndib && started) begin
                    axiiv = hold;
                end
            end
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: frame did not complete, captured %0d dibits", cap.size());
        end
    endtask

    task automatic check_frame(input string nm, input int ndib, input bit with_fcs,
                               input int exp_runts, output logic [31:0] fcs_v);
        int exp_len;
        int bad;
        logic [31:0] exp_fcs;
        logic [31:0] res;
        exp_len = 32 + ndib + (with_fcs ? 16 : 0);
        n_cmp++;
        if (cap.size() !== exp_len) begin
            n_err++; $display("FAIL %s_len: txen high %0d cycles, want %0d", nm, cap.size(), exp_len);
        end
        bad = 0;
        for (int i = 0; i < 31; i++) if (capd(i) !== 2'b01) bad++;
        if (capd(31) !== 2'b11) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL %s_preamble: %0d wrong dibits, want 0", nm, bad);
        end
        bad = 0;
        for (int i = 0; i < ndib; i++) if (capd(32 + i) !== pay[i]) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL %s_payload: %0d wrong dibits, want 0", nm, bad);
        end
        fcs_v = 32'h0;
        if (with_fcs) begin
            for (int i = 0; i < 16; i++) fcs_v[2*i +: 2] = capd(32 + ndib + i);
            exp_fcs = ~crc_run(pay, 0, ndib);
            n_cmp++;
            if (fcs_v !== exp_fcs) begin
                n_err++; $display("FAIL %s_fcs: got %h, want %h", nm, fcs_v, exp_fcs);
            end
            // Receive-side view: CRC over payload plus FCS lands on the fixed residue.
            res = crc_run(cap, 32, ndib + 16);
            n_cmp++;
            if (res !== 32'hDEBB20E3) begin
                n_err++; $display("FAIL %s_residue: got %h, want debb20e3", nm, res);
            end
        end
        n_cmp++;
        if (runts !== exp_runts) begin
            n_err++; $display("FAIL %s_runt: %0d pulses, want %0d", nm, runts, exp_runts);
        end
    endtask

    // Entered on the first IFG sample; walks the whole gap and the IDLE cycle after it.
    task automatic check_ifg(input string nm);
        int bad;
        axiiv = 1'b0;
        bad = 0;
        if (w_busy !== 1'b1 || w_txen !== 1'b0) bad++;
        for (int i = 1; i < 48; i++) begin
            @(negedge clk);
            if (w_busy !== 1'b1 || w_txen !== 1'b0 || w_txd !== 2'b00 || w_axiir !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL %s_ifg: %0d bad gap cycles, want 0", nm, bad);
        end
        @(negedge clk);
        n_cmp++;
        if (w_busy !== 1'b0 || w_txen !== 1'b0) begin
            n_err++; $display("FAIL %s_idle: busy=%b txen=%b, want 0 0", nm, w_busy, w_txen);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({txen_a, txd_a, busy_a, runt_a, axiir_a} !== 6'b0) begin
            n_err++; $display("FAIL reset_a: outputs %b, want 000000", {txen_a, txd_a, busy_a, runt_a, axiir_a});
        end
        n_cmp++;
        if ({txen_b, txd_b, busy_b, runt_b, axiir_b} !== 6'b0) begin
            n_err++; $display("FAIL reset_b: outputs %b, want 000000", {txen_b, txd_b, busy_b, runt_b, axiir_b});
        end
    endtask

    task automatic test_runt();
        logic [31:0] f;
        pay.delete();
        send(1'b0, 0, 1'b0, -1);
        check_frame("runt", 0, 1'b1, 1, f);
        n_cmp++;
        if (f !== 32'h00000000) begin
            n_err++; $display("FAIL runt_fcs_const: got %h, want 00000000", f);
        end
        check_ifg("runt");
    endtask

    task automatic test_known_vector();
        logic [31:0] f;
        pay.delete();
        for (int i = 0; i < 9; i++) load_byte(8'h31 + 8'(i));
        send(1'b0, 36, 1'b0, -1);
        n_cmp++;
        if (pre !== 0) begin
            n_err++; $display("FAIL kv_latency: txen rose after %0d cycles, want 0", pre);
        end
        check_frame("kv", 36, 1'b1, 0, f);
        n_cmp++;
        if (f !== 32'hCBF43926) begin
            n_err++; $display("FAIL kv_fcs_const: got %h, want cbf43926", f);
        end
        check_ifg("kv");
    endtask

    task automatic test_payload60();
        logic [31:0] f;
        pay.delete();
        for (int i = 0; i < 60; i++) load_byte(8'(i));
        send(1'b0, 240, 1'b0, -1);
        check_frame("p60", 240, 1'b1, 0, f);
        check_ifg("p60");
    endtask

    task automatic test_no_fcs();
        logic [31:0] f;
        pay.delete();
        load_byte(8'hDE); load_byte(8'hAD); load_byte(8'hBE); load_byte(8'hEF);
        send(1'b1, 16, 1'b0, -1);
        check_frame("nofcs", 16, 1'b0, 0, f);
        check_ifg("nofcs");
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] f;
        pay.delete();
        load_byte(8'hA5); load_byte(8'h5A); load_byte(8'h0F);
        gap_axiir = 0;
        send(1'b0, 12, 1'b1, -1);
        check_frame("b2b1", 12, 1'b1, 0, f);
        pay.delete();
        load_byte(8'hC3); load_byte(8'h3C);
        send(1'b0, 8, 1'b0, -1);
        // 47 remaining IFG samples plus one IDLE sample before txen rises again.
        n_cmp++;
        if (pre !== 48) begin
            n_err++; $display("FAIL b2b_gap: %0d more low cycles, want 48", pre);
        end
        n_cmp++;
        if (gap_axiir !== 0) begin
            n_err++; $display("FAIL b2b_axiir: ready high %0d gap cycles, want 0", gap_axiir);
        end
        check_frame("b2b2", 8, 1'b1, 0, f);
        check_ifg("b2b2");
    endtask

    task automatic test_short();
        logic [31:0] f;
        pay.delete();
        for (int i = 0; i < 8; i++) load_byte(8'h90 + 8'(i));
        send(1'b0, 7, 1'b0, -1);
        check_frame("short", 7, 1'b1, 0, f);
        check_ifg("short");
    endtask

    task automatic test_reset_midframe();
        logic [31:0] f;
        int bad;
        pay.delete();
        for (int i = 0; i < 10; i++) load_byte(8'h10 + 8'(i));
        send(1'b0, 40, 1'b0, 43);
        axiiv = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (w_txen !== 1'b0 || w_busy !== 1'b0 || w_axiir !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (w_txen !== 1'b0 || w_busy !== 1'b0 || w_axiir !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL rstmid_quiet: %0d active cycles, want 0", bad);
        end
        pay.delete();
        for (int i = 0; i < 6; i++) load_byte(8'h77 ^ 8'(i));
        send(1'b0, 24, 1'b0, -1);
        check_frame("rstmid", 24, 1'b1, 0, f);
        check_ifg("rstmid");
    endtask

    initial begin
        n_cmp = 0; n_err = 0; gap_axiir = 0;
        rst_n = 1'b0; axiiv = 1'b0; axiid = 2'b00; sel = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_runt();
        test_known_vector();
        test_payload60();
        test_no_fcs();
        test_back_to_back();
        test_short();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
